sine_dds_sample_gen: RTL



---
 rtl/sine_dds_pkg.sv | 24 ++
 rtl/sine_quarter_lut.sv | 26 ++
 rtl/sine_dds_sample_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/sine_dds_pkg.sv
// Shared constants for the sine DDS sample generator: quarter-wave table and
// offset-binary midpoints.
package sine_dds_pkg;

  localparam int LUT_AW_P  = 6;
  localparam int LUT_DEPTH = 1 << LUT_AW_P;
  localparam int LUT_DW    = 7;

  localparam logic [7:0] D_POS_BASE = 8'h80;
  localparam logic [7:0] D_NEG_BASE = 8'h7F;

  // round(127 * sin((i + 0.5) * pi / 128)); the half-step keeps the mirror exact
  localparam logic [LUT_DW-1:0] QSINE_LUT [LUT_DEPTH] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with a registered read (one cycle of latency).
module sine_quarter_lut
  import sine_dds_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] idx,
  output logic [LUT_DW-1:0] a
);

  logic [LUT_DW-1:0] a_q, a_d;

  always_comb begin
    a_d = QSINE_LUT[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) a_q <= '0;
    else        a_q <= a_d;
  end

  assign a = a_q;

endmodule

// File: rtl/sine_dds_sample_gen.sv
// DDS sample source feeding an 8-bit PWM; D only changes on PWM period wraps.
// Optional PHASE_WRAP trigger output enabled by defining SINE_DDS_PHASE_WRAP_EN.
module sine_dds_sample_gen
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int LUT_AW     = 6,
  parameter int PWM_PERIOD = 256
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [PHASE_W-1:0] FREQ_WORD,
  output logic [7:0]         D,
  output logic               CE,
  output logic               SAMPLE_STB
`ifdef SINE_DDS_PHASE_WRAP_EN
  ,
  output logic               PHASE_WRAP
`endif
);

  localparam int               CNT_W    = $clog2(PWM_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic               ce_q, ce_d;
  logic               stb_q, stb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         d_q, d_d;
  logic [1:0]         quad1_q, quad1_d;
  logic [LUT_AW-1:0]  idx1_q, idx1_d;
  logic [1:0]         quad2_q, quad2_d;
  logic [LUT_DW-1:0]  amp;
  logic [7:0]         d_next_q, d_next_d;
  logic               wrap;
`ifdef SINE_DDS_PHASE_WRAP_EN
  logic               pwrap_q, pwrap_d;
`endif

  assign wrap = ce_q && (cnt_q == CNT_LAST);

  // Period counter, phase accumulator and output word
  always_comb begin
    ce_d    = EN;
    stb_d   = wrap;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    d_d     = d_q;
`ifdef SINE_DDS_PHASE_WRAP_EN
    pwrap_d = 1'b0;
`endif
    if (ce_q) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    if (wrap) begin
      d_d = d_next_q;
`ifdef SINE_DDS_PHASE_WRAP_EN
      {pwrap_d, phase_d} = {1'b0, phase_q} + {1'b0, FREQ_WORD};
`else
      phase_d = phase_q + FREQ_WORD;
`endif
    end
  end

  // Free-running sample pipeline; settles 3 cycles after phase moves
  always_comb begin
    quad1_d  = phase_q[PHASE_W-1 -: 2];
    idx1_d   = phase_q[PHASE_W-3 -: LUT_AW] ^ {LUT_AW{quad1_d[0]}};
    quad2_d  = quad1_q;
    d_next_d = quad2_q[1] ? (D_NEG_BASE - {1'b0, amp})
                          : (D_POS_BASE + {1'b0, amp});
  end

  sine_quarter_lut #(.LUT_AW(LUT_AW)) u_lut (
    .clk   (CLK),
    .rst_n (RST_N),
    .idx   (idx1_q),
    .a     (amp)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ce_q     <= 1'b0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= '0;
      d_q      <= D_POS_BASE;
      quad1_q  <= '0;
      idx1_q   <= '0;
      quad2_q  <= '0;
      d_next_q <= D_POS_BASE;
    end else begin
      ce_q     <= ce_d;
      stb_q    <= stb_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      d_q      <= d_d;
      quad1_q  <= quad1_d;
      idx1_q   <= idx1_d;
      quad2_q  <= quad2_d;
      d_next_q <= d_next_d;
    end
  end

`ifdef SINE_DDS_PHASE_WRAP_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) pwrap_q <= 1'b0;
    else        pwrap_q <= pwrap_d;
  end

  assign PHASE_WRAP = pwrap_q;
`endif

  assign D          = d_q;
  assign CE         = ce_q;
  assign SAMPLE_STB = stb_q;

endmodule
